// File: rtl/lsu.sv
// lsu: load/store unit issuing one data-memory access per request over req/ready,
// aligning store lanes and sign/zero-extending loads.
module lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_rdata_i
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t      state;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] cnt;
    logic        legal, aligned, expired;
    logic [3:0]  be;
    logic [31:0] wd, sh, ld;
    always_comb begin
        legal   = we_i ? (funct3_i < 3'd3) : (funct3_i[1:0] != 2'b11 && funct3_i != 3'b110);
        aligned = funct3_i[1] ? (addr_i[1:0] == 2'b00) : funct3_i[0] ? !addr_i[0] : 1'b1;
        be      = funct3_i[1] ? 4'hF : funct3_i[0] ? 4'b0011 << addr_i[1:0] : 4'b0001 << addr_i[1:0];
        wd      = !we_i ? 32'd0 : funct3_i[1] ? wdata_i :
                  funct3_i[0] ? {2{wdata_i[15:0]}} : {4{wdata_i[7:0]}};
        sh      = mem_rdata_i >> {off, 3'b000};
        // f3[2] marks the unsigned variants, which suppress the sign fill
        ld      = f3[1] ? sh : f3[0] ? {{16{sh[15] & !f3[2]}}, sh[15:0]} :
                  {{24{sh[7] & !f3[2]}}, sh[7:0]};
        expired = TIMEOUT != 0 && cnt == 32'(TIMEOUT - 1);
    end
    // Gated by rst_i so an abort mid-access releases upstream immediately
    assign stall_o = !rst_i && ((state == IDLE && valid_i) || state == REQ);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            f3          <= 3'd0;
            off         <= 2'd0;
            cnt         <= 32'd0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            rdata_o     <= 32'd0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 32'd0;
            mem_wdata_o <= 32'd0;
            mem_be_o    <= 4'd0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                IDLE: if (valid_i) begin
                    f3  <= funct3_i;
                    off <= addr_i[1:0];
                    cnt <= 32'd0;
                    if (legal && aligned) begin
                        state       <= REQ;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= we_i;
                        mem_addr_o  <= {addr_i[31:2], 2'b00};
                        mem_wdata_o <= wd;
                        mem_be_o    <= be;
                    end else begin
                        state  <= DONE;
                        done_o <= 1'b1;
                        err_o  <= 1'b1;
                    end
                end
                REQ: if (mem_ready_i) begin
                    mem_req_o <= 1'b0;
                    if (!mem_we_o) rdata_o <= ld;
                    state  <= DONE;
                    done_o <= 1'b1;
                end else if (expired) begin
                    mem_req_o <= 1'b0;
                    state     <= DONE;
                    done_o    <= 1'b1;
                    err_o     <= 1'b1;
                end else begin
                    cnt <= cnt + 32'd1;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
